mips_multicycle_ctrl: RTL and testbench

- Multi-cycle issue/control stage directly upstream of the register file and ALU.
- Accepts one 32-bit MIPS instruction per valid/ready handshake and decodes it.
- Drives register-file read addresses and ALU op/shift/B-select, captures the ALU result and flags, then issues one register-file write.
- Also holds the writeback data register, replacing the ad-hoc result mux.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mips_decode.sv | 85 ++++++++
 rtl/mips_multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared encodings for the multi-cycle MIPS issue/control stage
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;
  localparam logic [3:0] ALU_LT  = 4'd8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_decode.sv
`default_nettype none
// ============================================================================
// mips_decode : combinational instruction decoder for the multi-cycle controller
// Revision    : 1.0
// ============================================================================
module mips_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  read1_o,
  output logic [4:0]  read2_o,
  output logic [4:0]  wrt_add_o,
  output logic [3:0]  alu_op_o,
  output logic [4:0]  alu_shft_o,
  output logic        b_sel_o,
  output logic [31:0] imm_ext_o,
  output logic        is_slt_o,
  output logic        chk_ovf_o,
  output logic        legal_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign opcode = instr_i[OPC_LSB +: 6];
  assign rs     = instr_i[RS_LSB +: 5];
  assign rt     = instr_i[RT_LSB +: 5];
  assign rd     = instr_i[RD_LSB +: 5];
  assign shamt  = instr_i[SHAMT_LSB +: 5];
  assign funct  = instr_i[FUNCT_LSB +: 6];
  assign imm    = instr_i[IMM_LSB +: 16];

  always_comb begin
    read1_o    = rs;
    read2_o    = rt;
    wrt_add_o  = rd;
    alu_op_o   = ALU_ADD;
    alu_shft_o = 5'd0;
    b_sel_o    = 1'b0;
    imm_ext_o  = 32'd0;
    is_slt_o   = 1'b0;
    chk_ovf_o  = 1'b0;
    legal_o    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal_o = 1'b1;
        case (funct)
          FN_ADD: begin alu_op_o = ALU_ADD; chk_ovf_o = 1'b1; end
          FN_SUB: begin alu_op_o = ALU_SUB; chk_ovf_o = 1'b1; end
          FN_AND: alu_op_o = ALU_AND;
          FN_OR:  alu_op_o = ALU_OR;
          // shifts operate on rt, so it is routed to the A port
          FN_SLL: begin alu_op_o = ALU_SLL; read1_o = rt; alu_shft_o = shamt; end
          FN_SRL: begin alu_op_o = ALU_SRL; read1_o = rt; alu_shft_o = shamt; end
          FN_SRA: begin alu_op_o = ALU_SRA; read1_o = rt; alu_shft_o = shamt; end
          FN_SLT: begin alu_op_o = ALU_LT;  is_slt_o = 1'b1; end
          default: legal_o = 1'b0;
        endcase
      end
      OP_ADDI: begin
        legal_o   = 1'b1;
        alu_op_o  = ALU_ADD;
        b_sel_o   = 1'b1;
        imm_ext_o = sign_ext16(imm);
        wrt_add_o = rt;
        chk_ovf_o = 1'b1;
      end
      OP_ORI: begin
        legal_o   = 1'b1;
        alu_op_o  = ALU_OR;
        b_sel_o   = 1'b1;
        imm_ext_o = {16'd0, imm};
        wrt_add_o = rt;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// mips_multicycle_ctrl : 4-cycle issue/control stage driving regfile and ALU
// Revision             : 1.0
// ============================================================================
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit ZERO_REG_PROTECT = 1'b1,
  parameter bit TRAP_ON_OVF      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_overflow_i,
  input  logic        alu_lessthan_i,
  output logic [4:0]  read1_o,
  output logic [4:0]  read2_o,
  output logic [3:0]  alu_op_o,
  output logic [4:0]  alu_shft_o,
  output logic        b_sel_o,
  output logic [31:0] imm_ext_o,
  output logic [4:0]  wrt_add_o,
  output logic        wrt_en_o,
  output logic [31:0] wb_data_o,
  output logic        done_o,
  output logic        illegal_o,
  output logic        ovf_err_o
);

  state_t      state_q;
  logic [31:0] instr_q;
  logic [4:0]  read1_q;
  logic [4:0]  read2_q;
  logic [4:0]  wrt_add_q;
  logic [3:0]  alu_op_q;
  logic [4:0]  alu_shft_q;
  logic        b_sel_q;
  logic [31:0] imm_ext_q;
  logic        is_slt_q;
  logic        chk_ovf_q;
  logic [31:0] wb_data_q;
  logic        wrt_en_q;
  logic        done_q;
  logic        illegal_q;
  logic        ovf_err_q;

  logic [4:0]  dec_read1;
  logic [4:0]  dec_read2;
  logic [4:0]  dec_wrt_add;
  logic [3:0]  dec_alu_op;
  logic [4:0]  dec_alu_shft;
  logic        dec_b_sel;
  logic [31:0] dec_imm_ext;
  logic        dec_is_slt;
  logic        dec_chk_ovf;
  logic        dec_legal;

  logic        ovf_hit;
  logic        ovf_trap;
  logic [31:0] wb_data_d;
  logic        wrt_en_d;

  mips_decode u_decode (
    .instr_i    (instr_q),
    .read1_o    (dec_read1),
    .read2_o    (dec_read2),
    .wrt_add_o  (dec_wrt_add),
    .alu_op_o   (dec_alu_op),
    .alu_shft_o (dec_alu_shft),
    .b_sel_o    (dec_b_sel),
    .imm_ext_o  (dec_imm_ext),
    .is_slt_o   (dec_is_slt),
    .chk_ovf_o  (dec_chk_ovf),
    .legal_o    (dec_legal)
  );

  // The ALU leaves overflow undefined for non-arithmetic ops; only a hard 1 counts.
  assign ovf_hit   = chk_ovf_q & (alu_overflow_i === 1'b1);
  assign ovf_trap  = TRAP_ON_OVF & ovf_hit;
  assign wb_data_d = is_slt_q ? {31'd0, alu_lessthan_i} : alu_result_i;
  assign wrt_en_d  = ~ovf_trap & ~(ZERO_REG_PROTECT & (wrt_add_q == 5'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= 32'd0;
      read1_q    <= 5'd0;
      read2_q    <= 5'd0;
      wrt_add_q  <= 5'd0;
      alu_op_q   <= 4'd0;
      alu_shft_q <= 5'd0;
      b_sel_q    <= 1'b0;
      imm_ext_q  <= 32'd0;
      is_slt_q   <= 1'b0;
      chk_ovf_q  <= 1'b0;
      wb_data_q  <= 32'd0;
      wrt_en_q   <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      wrt_en_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ovf_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            instr_q <= instr_i;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            read1_q    <= dec_read1;
            read2_q    <= dec_read2;
            wrt_add_q  <= dec_wrt_add;
            alu_op_q   <= dec_alu_op;
            alu_shft_q <= dec_alu_shft;
            b_sel_q    <= dec_b_sel;
            imm_ext_q  <= dec_imm_ext;
            is_slt_q   <= dec_is_slt;
            chk_ovf_q  <= dec_chk_ovf;
            state_q    <= EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        EXEC: begin
          wb_data_q <= wb_data_d;
          wrt_en_q  <= wrt_en_d;
          done_q    <= 1'b1;
          ovf_err_q <= ovf_trap;
          state_q   <= WB;
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready_o = rst_n & (state_q == IDLE);
  assign read1_o       = read1_q;
  assign read2_o       = read2_q;
  assign alu_op_o      = alu_op_q;
  assign alu_shft_o    = alu_shft_q;
  assign b_sel_o       = b_sel_q;
  assign imm_ext_o     = imm_ext_q;
  assign wrt_add_o     = wrt_add_q;
  assign wrt_en_o      = wrt_en_q;
  assign wb_data_o     = wb_data_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
  assign ovf_err_o     = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips_multicycle_ctrl : scoreboard bench, trapping/protected and plain instances
// Revision                : 1.0
// ============================================================================
module tb_mips_multicycle_ctrl;

  localparam int N = 2;  // instance 0: protect+trap on, instance 1: both off

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  instr_valid;
  logic [31:0]           instr;
  logic [N-1:0]          instr_ready;
  logic [N-1:0][31:0]    alu_result;
  logic [N-1:0]          alu_overflow;
  logic [N-1:0]          alu_lessthan;
  logic [N-1:0][4:0]     read1, read2, alu_shft, wrt_add;
  logic [N-1:0][3:0]     alu_op;
  logic [N-1:0]          b_sel, wrt_en, done, illegal, ovf_err;
  logic [N-1:0][31:0]    imm_ext, wb_data;

  mips_multicycle_ctrl #(.ZERO_REG_PROTECT(1'b1), .TRAP_ON_OVF(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready[0]),
    .instr_i(instr), .alu_result_i(alu_result[0]), .alu_overflow_i(alu_overflow[0]),
    .alu_lessthan_i(alu_lessthan[0]), .read1_o(read1[0]), .read2_o(read2[0]),
    .alu_op_o(alu_op[0]), .alu_shft_o(alu_shft[0]), .b_sel_o(b_sel[0]),
    .imm_ext_o(imm_ext[0]), .wrt_add_o(wrt_add[0]), .wrt_en_o(wrt_en[0]),
    .wb_data_o(wb_data[0]), .done_o(done[0]), .illegal_o(illegal[0]), .ovf_err_o(ovf_err[0]));

  mips_multicycle_ctrl #(.ZERO_REG_PROTECT(1'b0), .TRAP_ON_OVF(1'b0)) dut_plain (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready[1]),
    .instr_i(instr), .alu_result_i(alu_result[1]), .alu_overflow_i(alu_overflow[1]),
    .alu_lessthan_i(alu_lessthan[1]), .read1_o(read1[1]), .read2_o(read2[1]),
    .alu_op_o(alu_op[1]), .alu_shft_o(alu_shft[1]), .b_sel_o(b_sel[1]),
    .imm_ext_o(imm_ext[1]), .wrt_add_o(wrt_add[1]), .wrt_en_o(wrt_en[1]),
    .wb_data_o(wb_data[1]), .done_o(done[1]), .illegal_o(illegal[1]), .ovf_err_o(ovf_err[1]));

  // ---------------- environment: register files and ALUs ----------------
  logic [31:0] rf [N][32];
  logic [31:0] seed [32];
  logic        seed_en = 1'b0;

  // returns {overflow, lessthan, result}; overflow is junk (1) outside add/sub
  function automatic logic [33:0] alu_env(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [4:0] sh);
    logic [31:0] r;
    logic        ov, lt;
    lt = ($signed(a) < $signed(b));
    ov = 1'b1;
    case (op)
      4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a << sh;
      4'd5: r = a >> sh;
      4'd6: r = $signed(a) >>> sh;
      4'd8: r = {31'd0, lt};
      default: r = 32'hDEAD_BEEF;
    endcase
    return {ov, lt, r};
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_env
    assign {alu_overflow[k], alu_lessthan[k], alu_result[k]} =
      alu_env(alu_op[k], rf[k][read1[k]], b_sel[k] ? imm_ext[k] : rf[k][read2[k]], alu_shft[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (seed_en) begin
        for (int i = 0; i < 32; i++) rf[k][i] <= seed[i];
      end else if (wrt_en[k]) begin
        rf[k][wrt_add[k]] <= wb_data[k];
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        ill;
    logic [4:0]  wa;
    logic [4:0]  r1;
    logic        bsel;
    logic [31:0] imm;
    logic        we0, oe0, we1, oe1;
    logic [31:0] wd0, wd1;
    logic [31:0] acc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural reference: one instruction at a time on a plain register array.
  logic [31:0] ref_rf [N][32];

  task automatic model(input logic [31:0] ins, input logic [31:0] s, t, input bit trap, prot,
                       output bit ill, we, oe, output logic [4:0] wa, r1,
                       output bit bsel, output logic [31:0] imm, wd);
    logic [5:0] opc, fn;
    logic [4:0] sh;
    longint a, b, r;
    logic signed [31:0] lo;
    bit ovf;
    opc = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
    ill = 0; ovf = 0; bsel = 0; imm = 0; wd = 0;
    r1 = ins[25:21]; wa = ins[15:11];
    a = $signed(s); b = $signed(t); r = 0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: r = a + b;
        6'h22: r = a - b;
        6'h24: wd = s & t;
        6'h25: wd = s | t;
        6'h00: begin wd = t << sh; r1 = ins[20:16]; end
        6'h02: begin wd = t >> sh; r1 = ins[20:16]; end
        6'h03: begin wd = $signed(t) >>> sh; r1 = ins[20:16]; end
        6'h2A: wd = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
        default: ill = 1;
      endcase
      if (fn == 6'h20 || fn == 6'h22) begin
        lo = r[31:0]; wd = r[31:0]; ovf = (r != lo);
      end
    end else if (opc == 6'h08) begin
      imm = {{16{ins[15]}}, ins[15:0]}; bsel = 1; wa = ins[20:16];
      b = $signed(imm); r = a + b; lo = r[31:0]; wd = r[31:0]; ovf = (r != lo);
    end else if (opc == 6'h0D) begin
      imm = {16'd0, ins[15:0]}; bsel = 1; wa = ins[20:16]; wd = s | imm;
    end else begin
      ill = 1;
    end
    oe = !ill && trap && ovf;
    we = !ill && !oe && !(prot && wa == 5'd0);
  endtask

  always @(negedge clk) begin
    exp_t me;
    if (rst_n) begin
      for (int k = 0; k < N; k++)
        if (wrt_en[k]) chk($sformatf("wrt_en_without_done%0d", k), done[k], 1);
      if ((done | illegal) != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", {done, illegal}, 0);
        end else begin
          me = q.pop_front();
          chk("done0", done[0], !me.ill);
          chk("illegal0", illegal[0], me.ill);
          chk("done1", done[1], !me.ill);
          chk("illegal1", illegal[1], me.ill);
          chk("latency", cyc - me.acc, me.ill ? 1 : 2);
          chk("wrt_en0", wrt_en[0], me.we0);
          chk("wrt_en1", wrt_en[1], me.we1);
          chk("ovf_err0", ovf_err[0], me.oe0);
          chk("ovf_err1", ovf_err[1], me.oe1);
          if (!me.ill) begin
            chk("wb_data0", wb_data[0], me.wd0);
            chk("wb_data1", wb_data[1], me.wd1);
            chk("wrt_add0", wrt_add[0], me.wa);
            chk("read1_0", read1[0], me.r1);
            chk("b_sel0", b_sel[0], me.bsel);
            chk("imm_ext0", imm_ext[0], me.imm);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int unsigned last_acc = 0;
  bit prev_hold = 0;
  bit prev_ill = 0;

  function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [5:0] FUNCTS [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03, 6'h2A};

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd, sh;
    logic [5:0] op, fn;
    logic [15:0] imm;
    int sel;
    rs = 5'($urandom_range(0, 19)); rt = 5'($urandom_range(0, 19));
    rd = 5'($urandom_range(0, 19)); sh = 5'($urandom);
    imm = 16'($urandom);
    sel = $urandom_range(0, 11);
    if (sel < 8) return mk_r(rs, rt, rd, sh, FUNCTS[sel]);
    if (sel == 8) return mk_i(6'h08, rs, rt, imm);
    if (sel == 9) return mk_i(6'h0D, rs, rt, imm);
    if (sel == 10) begin
      fn = 6'($urandom);
      foreach (FUNCTS[j]) if (fn == FUNCTS[j]) fn = 6'h3F;
      return mk_r(rs, rt, rd, sh, fn);
    end
    op = 6'($urandom);
    if (op == 6'h00 || op == 6'h08 || op == 6'h0D) op = 6'h3F;
    return mk_i(op, rs, rt, imm);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] ins, input bit hold);
    int w;
    exp_t e;
    bit ill, we, oe, bs;
    logic [4:0] wa, r1;
    logic [31:0] im, wd;
    instr = ins;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready[0] && w < 20) begin @(negedge clk); w++; end
    if (!instr_ready[0]) begin
      chk("accept_timeout", instr_ready[0], 1);
      instr_valid = 1'b0;
      return;
    end
    chk("ready_match", instr_ready[1], instr_ready[0]);
    if (prev_hold) chk("accept_gap", cyc + 1 - last_acc, prev_ill ? 2 : 4);
    e = '0;
    e.acc = cyc + 1;
    for (int k = 0; k < N; k++) begin
      model(ins, ref_rf[k][ins[25:21]], ref_rf[k][ins[20:16]], k == 0, k == 0,
            ill, we, oe, wa, r1, bs, im, wd);
      if (we) ref_rf[k][wa] = wd;
      if (k == 0) begin e.we0 = we; e.oe0 = oe; e.wd0 = wd; end
      else        begin e.we1 = we; e.oe1 = oe; e.wd1 = wd; end
    end
    e.ill = ill; e.wa = wa; e.r1 = r1; e.bsel = bs; e.imm = im;
    q.push_back(e);
    last_acc = cyc + 1;
    prev_hold = hold;
    prev_ill = ill;
    @(posedge clk);
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    int w;
    instr_valid = 1'b0;
    instr = 32'd0;
    for (int i = 0; i < 32; i++) seed[i] = (i < 16) ? 32'(i) : $urandom;
    seed[16] = 32'h7FFF_FFFF; seed[17] = 32'h7FFF_FFFF;
    seed[18] = 32'h8000_0000; seed[19] = 32'hFFFF_FFFF;
    for (int k = 0; k < N; k++) for (int i = 0; i < 32; i++) ref_rf[k][i] = seed[i];
    seed_en = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_read1", read1[k], 0);      chk("rst_read2", read2[k], 0);
      chk("rst_wrt_add", wrt_add[k], 0);  chk("rst_alu_op", alu_op[k], 0);
      chk("rst_alu_shft", alu_shft[k], 0); chk("rst_imm_ext", imm_ext[k], 0);
      chk("rst_wb_data", wb_data[k], 0);  chk("rst_b_sel", b_sel[k], 0);
      chk("rst_wrt_en", wrt_en[k], 0);    chk("rst_done", done[k], 0);
      chk("rst_illegal", illegal[k], 0);  chk("rst_ovf_err", ovf_err[k], 0);
    end
    seed_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready0", instr_ready[0], 1);
    chk("rst_ready1", instr_ready[1], 1);
    @(negedge clk);

    // directed cases
    issue(mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0);          // add $3,$1,$2
    issue(32'h2085_FFFF, 0);                                // addi $5,$4,-1
    issue(mk_i(6'h0D, 5'd0, 5'd6, 16'h8000), 0);            // ori $6,$0,0x8000
    issue(mk_r(5'd0, 5'd18, 5'd7, 5'd1, 6'h03), 0);         // sra $7,$18,1
    issue(mk_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h2A), 0);          // slt $8,$1,$2
    issue(mk_r(5'd16, 5'd17, 5'd9, 5'd0, 6'h20), 0);        // add overflow
    issue(mk_i(6'h08, 5'd16, 5'd10, 16'h0001), 0);          // addi overflow
    issue({6'h3F, 26'd0}, 0);                               // illegal opcode
    issue(mk_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 0);          // add $0,$1,$2
    issue(mk_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h21), 0);          // illegal funct
    repeat (2) @(negedge clk);

    // back-to-back burst with valid held high
    for (int n = 0; n < 6; n++) issue(rand_instr(), n < 5);

    for (int n = 0; n < 200; n++) begin
      issue(rand_instr(), $urandom_range(0, 2) != 0);
      if (instr_valid == 1'b0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    instr_valid = 1'b0;
    prev_hold = 0;

    w = 0;
    while (q.size() != 0 && w < 50) begin @(negedge clk); w++; end
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 32; i++)
        chk($sformatf("regfile%0d_r%0d", k, i), rf[k][i], ref_rf[k][i]);

    // reset during EXEC must abort without a write
    ins = mk_i(6'h0D, 5'd0, 5'd10, ~ref_rf[0][10][15:0]);
    instr = ins;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready[0] && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("abort_wrt_en", wrt_en[k], 0);
      chk("abort_done", done[k], 0);
      chk("abort_wrt_add", wrt_add[k], 0);
      chk("abort_b_sel", b_sel[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready0", instr_ready[0], 1);
    chk("abort_ready1", instr_ready[1], 1);
    repeat (6) @(negedge clk);
    for (int k = 0; k < N; k++) chk("abort_r10_kept", rf[k][10], ref_rf[k][10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
